// File: rtl/stopwatch_btn_ctrl_pkg.sv
// Shared definitions for the stopwatch button front end: debounce state
// encodings and the default debounce lengths for hardware and simulation.
package stopwatch_btn_ctrl_pkg;

   typedef enum logic [1:0] {
      DB_ZERO  = 2'b00,
      DB_WAIT1 = 2'b01,
      DB_ONE   = 2'b10,
      DB_WAIT0 = 2'b11
   } db_state_t;

   // 20 ms at 100 MHz for silicon; a short window keeps simulations fast.
   localparam int DB_CYCLES_HW  = 2_000_000;
   localparam int DB_CYCLES_SIM = 8;
   localparam int CNT_W_HW      = 21;

endpackage

// File: rtl/stopwatch_btn_ctrl_if.sv
// Button-side and stopwatch-side signals of the control stage.
// The slave modport is the view of the control block itself.
interface stopwatch_btn_ctrl_if;

   logic btn_go_raw;
   logic btn_clr_raw;
   logic go;
   logic clr;
   logic go_db;
   logic clr_db;

   modport master (
      output btn_go_raw, btn_clr_raw,
      input  go, clr, go_db, clr_db
   );

   modport slave (
      input  btn_go_raw, btn_clr_raw,
      output go, clr, go_db, clr_db
   );

endinterface

// File: rtl/stopwatch_btn_ctrl_btn_debounce.sv
// One pushbutton: 2-flop synchroniser, 4-state debounce FSM with a
// down-counter, and a registered one-cycle tick per accepted press.
module btn_debounce
   import stopwatch_btn_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_HW,
   parameter int CNT_W     = CNT_W_HW
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic tick
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

   logic             sync1;
   logic             s;
   db_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             tick_nxt;

   // Bring the asynchronous button into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
      end else begin
         // NOTE: non-blocking so the two flops form a real 2-stage chain;
         // blocking would collapse them into one.
         sync1 <= raw;
         s     <= sync1;
      end
   end

   // FSM state, qualification counter and tick register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DB_ZERO;
         cnt   <= '0;
         tick  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tick  <= tick_nxt;
      end
   end

   // Next-state: a level change is accepted only after DB_CYCLES stable samples.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      tick_nxt  = 1'b0;
      unique case (state)
         DB_ZERO: begin
            if (s) begin
               state_nxt = DB_WAIT1;
               cnt_nxt   = CNT_LOAD;
            end
         end
         DB_WAIT1: begin
            if (!s) begin
               state_nxt = DB_ZERO;
            end else if (cnt == '0) begin
               state_nxt = DB_ONE;
               tick_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         DB_ONE: begin
            if (!s) begin
               state_nxt = DB_WAIT0;
               cnt_nxt   = CNT_LOAD;
            end
         end
         DB_WAIT0: begin
            if (s) begin
               state_nxt = DB_ONE;
            end else if (cnt == '0) begin
               state_nxt = DB_ZERO;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = DB_ZERO;
         end
      endcase
   end

   assign level = (state == DB_ONE) || (state == DB_WAIT0);

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch front end: debounces start/stop and clear buttons and turns
// their press ticks into a go level and a one-cycle clr pulse.
module stopwatch_btn_ctrl
   import stopwatch_btn_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_HW,
   parameter int CNT_W     = CNT_W_HW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stopwatch_btn_ctrl_if.slave  bus
);

   logic go_level, go_tick;
   logic clr_level, clr_tick;
   logic go_q, clr_q;

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_go (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.btn_go_raw),
      .level (go_level),
      .tick  (go_tick)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.btn_clr_raw),
      .level (clr_level),
      .tick  (clr_tick)
   );

   // Clear wins over start/stop, so go and clr are never high together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         go_q  <= 1'b0;
         clr_q <= 1'b0;
      end else if (clr_tick) begin
         go_q  <= 1'b0;
         clr_q <= 1'b1;
      end else if (go_tick) begin
         go_q  <= ~go_q;
         clr_q <= 1'b0;
      end else begin
         clr_q <= 1'b0;
      end
   end

   assign bus.go     = go_q;
   assign bus.clr    = clr_q;
   assign bus.go_db  = go_level;
   assign bus.clr_db = clr_level;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Bench for stopwatch_btn_ctrl with a short debounce window. A run-length
// reference model predicts every output each cycle; directed scenarios add
// latency and pulse-count checks, then random button activity follows.
module tb_stopwatch_btn_ctrl;

   localparam int DB = 8;
   localparam int CW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   stopwatch_btn_ctrl_if bus();

   stopwatch_btn_ctrl #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Reference model: the sampled button is the raw value two edges back;
   // a level flips once DB+1 consecutive samples disagree with it.
   bit m_s1[2], m_s[2], m_level[2], m_tick[2];
   int m_run[2];
   bit m_go, m_clr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s[b] = 0; m_level[b] = 0; m_tick[b] = 0; m_run[b] = 0;
         end
         m_go  = 0;
         m_clr = 0;
      end else begin
         if (m_tick[1]) begin
            m_clr = 1; m_go = 0;
         end else if (m_tick[0]) begin
            m_go = !m_go; m_clr = 0;
         end else begin
            m_clr = 0;
         end
         for (int b = 0; b < 2; b++) begin
            m_tick[b] = 0;
            if (m_s[b] != m_level[b]) begin
               m_run[b]++;
               if (m_run[b] == DB + 1) begin
                  m_level[b] = m_s[b];
                  m_tick[b]  = m_s[b];
                  m_run[b]   = 0;
               end
            end else begin
               m_run[b] = 0;
            end
            m_s[b] = m_s1[b];
         end
         m_s1[0] = bus.btn_go_raw;
         m_s1[1] = bus.btn_clr_raw;
      end
   end

   bit chk_en     = 0;
   bit prev_clr   = 0;
   int clr_pulses = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("go",        32'(bus.go),     32'(m_go));
         check("clr",       32'(bus.clr),    32'(m_clr));
         check("go_db",     32'(bus.go_db),  32'(m_level[0]));
         check("clr_db",    32'(bus.clr_db), 32'(m_level[1]));
         check("go_and_clr", 32'(bus.go & bus.clr), 32'(0));
         check("clr_double", 32'(prev_clr & bus.clr), 32'(0));
         prev_clr = bus.clr;
         if (bus.clr) clr_pulses++;
      end
   end

   task automatic drive(input bit g, input bit c);
      bus.btn_go_raw  = g;
      bus.btn_clr_raw = c;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits (bounded) for go to reach val; returns the edge index or -1.
   task automatic wait_go(input bit val, input int budget, output int when);
      when = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.go === val) begin
            when = cyc;
            break;
         end
      end
   endtask

   int e0, t;

   initial begin
      drive(1, 1);
      chk_en = 1;
      // 1: reset held with both buttons pressed
      idle(20);
      check("rst_go",     32'(bus.go),     32'(0));
      check("rst_clr",    32'(bus.clr),    32'(0));
      check("rst_go_db",  32'(bus.go_db),  32'(0));
      check("rst_clr_db", 32'(bus.clr_db), 32'(0));
      #2 rst_n = 1;
      idle(1);
      drive(0, 0);
      idle(10);
      check("post_rst_go_db", 32'(bus.go_db), 32'(0));
      idle(10);

      // 2: clean press toggles go on, second press toggles it off
      drive(1, 0);
      e0 = cyc + 1;
      wait_go(1, 30, t);
      check("go_rise_lat", 32'(t - e0), 32'(11));
      idle(40 - (cyc - e0));
      drive(0, 0);
      idle(20);
      drive(1, 0);
      e0 = cyc + 1;
      wait_go(0, 30, t);
      check("go_fall_lat", 32'(t - e0), 32'(11));
      idle(20);
      drive(0, 0);
      idle(20);

      // 3: bouncy press gives one toggle; bouncy release gives none
      for (int i = 0; i < 6; i++) begin
         drive(1, 0); idle(3);
         drive(0, 0); idle(2);
      end
      drive(1, 0);
      e0 = cyc + 1;
      wait_go(1, 30, t);
      check("bounce_lat", 32'(t - e0), 32'(11));
      idle(10);
      for (int i = 0; i < 6; i++) begin
         drive(0, 0); idle(3);
         drive(1, 0); idle(2);
      end
      drive(0, 0);
      idle(20);
      check("bounce_rel_go", 32'(bus.go), 32'(1));

      // 4: held clear while running gives one pulse and stops go
      clr_pulses = 0;
      drive(0, 1);
      idle(100);
      check("clr_pulses_held", 32'(clr_pulses), 32'(1));
      check("clr_stops_go",    32'(bus.go),     32'(0));
      drive(0, 0);
      idle(20);

      // 5: simultaneous presses: clear wins
      clr_pulses = 0;
      drive(1, 1);
      idle(40);
      check("both_clr_pulses", 32'(clr_pulses), 32'(1));
      check("both_go",         32'(bus.go),     32'(0));
      drive(0, 0);
      idle(20);

      // 6: reset mid-qualification forces full re-qualification
      drive(1, 0);
      e0 = cyc + 1;
      idle(e0 + 6 - cyc);
      #2 rst_n = 0;
      idle(3);
      #2 rst_n = 1;
      e0 = cyc + 1;
      wait_go(1, 30, t);
      check("rst_requal_lat", 32'(t - e0), 32'(11));
      idle(5);
      drive(0, 0);
      idle(20);

      // Random button activity, with occasional resets
      for (int seg = 0; seg < 80; seg++) begin
         if ($urandom_range(0, 19) == 0) begin
            #2 rst_n = 0;
            idle(2);
            #2 rst_n = 1;
         end
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
         idle($urandom_range(1, 14));
      end
      drive(0, 0);
      idle(20);

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
